sync_fifo: RTL



---
 rtl/fifo_pkg.sv | 16 +
 rtl/sync_fifo_if.sv | 39 +++
 rtl/sync_fifo_ram_sdp.sv | 40 ++++
 rtl/sync_fifo.sv | 117 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo slice.
// Holds the default geometry constants and the pointer-increment helper
// used for wrap-around addressing of an arbitrary-depth ring buffer.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DATA_DEPTH = 128;

  // Next ring-buffer index; wraps from depth-1 back to 0 so non-power-of-two
  // depths work without relying on natural binary rollover.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Bus bundle between a producer/consumer and sync_fifo.
// master : drives clr, wr_en, data_in, rd_en; observes data and status.
// slave  : the FIFO itself.
// Signals: clr (sync clear), wr_en/data_in (write side), rd_en (read request),
//          data_out/rd_valid (registered read result), full/empty/
//          almost_full/almost_empty/count (occupancy), overflow/underflow
//          (sticky error flags).
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
);

  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram_sdp.sv
// Simple dual-port memory: one write port with write enable, one read port
// with read enable and a registered output.
// Ports: clk, rst_n (resets only the read register), we_i/waddr_i/wdata_i
//        (write), re_i/raddr_i (read request), rdata_o (holds when re_i low).
module ram_sdp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 128,
  parameter int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO over ram_sdp with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Ports: clk, rst_n (async active-low), bus (sync_fifo_if.slave carrying
//        clr, wr_en, data_in, rd_en, data_out, rd_valid, full, empty,
//        almost_full, almost_empty, count, overflow, underflow).
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_DEPTH + 1),
  parameter int unsigned AFULL_TH   = DATA_DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DATA_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // clr gates acceptance so neither the memory nor data_out move that cycle.
  assign wr_acc = bus.wr_en & ~full  & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty & ~bus.clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), DATA_DEPTH));
      end
      if (rd_acc) begin
        rd_ptr_d = ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), DATA_DEPTH));
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.data_out)
  );

  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (32'(count_q) >= AFULL_TH);
  assign bus.almost_empty = (32'(count_q) <= AEMPTY_TH);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
